// File: rtl/bus_decode_wdog.sv
// Registered single-master interconnect: decodes each Core request to RAM (slave 0) or the
// device window (slave 1), and raises err on unmapped addresses or slaves that never ack.
module bus_decode_wdog #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h0001_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_FF00,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    input  logic        m_wen_i,
    input  logic [3:0]  m_sel_i,
    input  logic        m_stb_i,
    input  logic        m_cyc_i,
    output logic [31:0] m_dat_o,
    output logic        m_ack_o,
    output logic        m_err_o,
    output logic        m_rty_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_wen_o,
    output logic [3:0]  s_sel_o,
    output logic        s0_stb_o,
    input  logic [31:0] s0_dat_i,
    input  logic        s0_ack_i,
    output logic        s1_stb_o,
    input  logic [31:0] s1_dat_i,
    input  logic        s1_ack_i,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        sel_s1, sel_s1_nxt;
    logic        abort, abort_nxt;
    logic [7:0]  tmo_cnt, tmo_cnt_nxt;
    logic [31:0] m_dat_nxt, s_adr_nxt, s_dat_nxt;
    logic        m_ack_nxt, m_err_nxt, s_wen_nxt, s0_stb_nxt, s1_stb_nxt;
    logic [3:0]  s_sel_nxt;
    logic [7:0]  err_cnt_nxt, err_cnt_inc;
    logic        hit_s0, hit_s1, slave_ack;
    logic [31:0] slave_dat;

    assign hit_s1      = (m_adr_i & S1_MASK) == S1_BASE;
    assign hit_s0      = (m_adr_i & S0_MASK) == S0_BASE;
    assign slave_ack   = sel_s1 ? s1_ack_i : s0_ack_i;
    assign slave_dat   = sel_s1 ? s1_dat_i : s0_dat_i;
    assign err_cnt_inc = (err_cnt_o == 8'hFF) ? 8'hFF : err_cnt_o + 8'd1;
    assign m_rty_o     = 1'b0;

    always_comb begin
        state_nxt   = state;
        sel_s1_nxt  = sel_s1;
        abort_nxt   = abort;
        tmo_cnt_nxt = tmo_cnt;
        m_dat_nxt   = m_dat_o;
        m_ack_nxt   = 1'b0;
        m_err_nxt   = m_err_o;
        s_adr_nxt   = s_adr_o;
        s_dat_nxt   = s_dat_o;
        s_wen_nxt   = s_wen_o;
        s_sel_nxt   = s_sel_o;
        s0_stb_nxt  = s0_stb_o;
        s1_stb_nxt  = s1_stb_o;
        err_cnt_nxt = err_cnt_o;

        case (state)
            IDLE: begin
                m_err_nxt = 1'b0;
                if (m_stb_i && m_cyc_i) begin
                    s_adr_nxt   = m_adr_i;
                    s_dat_nxt   = m_dat_i;
                    s_wen_nxt   = m_wen_i;
                    s_sel_nxt   = m_sel_i;
                    tmo_cnt_nxt = 8'd0;
                    abort_nxt   = 1'b0;
                    // Device window is checked first so it can overlay RAM space.
                    if (hit_s1) begin
                        sel_s1_nxt = 1'b1;
                        s1_stb_nxt = 1'b1;
                        state_nxt  = BUSY;
                    end else if (hit_s0) begin
                        sel_s1_nxt = 1'b0;
                        s0_stb_nxt = 1'b1;
                        state_nxt  = BUSY;
                    end else begin
                        m_err_nxt   = 1'b1;
                        err_cnt_nxt = err_cnt_inc;
                        state_nxt   = ERR;
                    end
                end
            end

            BUSY: begin
                if (!m_stb_i) begin
                    abort_nxt = 1'b1;
                end
                // An ack arriving on the last allowed cycle still beats the watchdog.
                if (slave_ack) begin
                    s0_stb_nxt = 1'b0;
                    s1_stb_nxt = 1'b0;
                    m_dat_nxt  = slave_dat;
                    if (abort || !m_stb_i) begin
                        state_nxt = IDLE;
                    end else begin
                        m_ack_nxt = 1'b1;
                        state_nxt = RESP;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    s0_stb_nxt  = 1'b0;
                    s1_stb_nxt  = 1'b0;
                    m_err_nxt   = 1'b1;
                    err_cnt_nxt = err_cnt_inc;
                    state_nxt   = ERR;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            ERR: begin
                if (!m_stb_i) begin
                    m_err_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel_s1    <= 1'b0;
            abort     <= 1'b0;
            tmo_cnt   <= 8'd0;
            m_dat_o   <= 32'd0;
            m_ack_o   <= 1'b0;
            m_err_o   <= 1'b0;
            s_adr_o   <= 32'd0;
            s_dat_o   <= 32'd0;
            s_wen_o   <= 1'b0;
            s_sel_o   <= 4'd0;
            s0_stb_o  <= 1'b0;
            s1_stb_o  <= 1'b0;
            err_cnt_o <= 8'd0;
        end else begin
            state     <= state_nxt;
            sel_s1    <= sel_s1_nxt;
            abort     <= abort_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            m_dat_o   <= m_dat_nxt;
            m_ack_o   <= m_ack_nxt;
            m_err_o   <= m_err_nxt;
            s_adr_o   <= s_adr_nxt;
            s_dat_o   <= s_dat_nxt;
            s_wen_o   <= s_wen_nxt;
            s_sel_o   <= s_sel_nxt;
            s0_stb_o  <= s0_stb_nxt;
            s1_stb_o  <= s1_stb_nxt;
            err_cnt_o <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_bus_decode_wdog.sv
// Self-checking bench for bus_decode_wdog: directed cases plus randomized transactions
// scored against a transaction-level model of the decode map, latency and watchdog.
module tb_bus_decode_wdog;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_adr_i, m_dat_i, m_dat_o, s_adr_o, s_dat_o, s0_dat_i, s1_dat_i;
    logic        m_wen_i, m_stb_i, m_cyc_i, m_ack_o, m_err_o, m_rty_o, s_wen_o;
    logic [3:0]  m_sel_i, s_sel_o;
    logic        s0_stb_o, s0_ack_i, s1_stb_o, s1_ack_i;
    logic [7:0]  err_cnt_o;

    int compared   = 0;
    int mismatched = 0;
    int errCnt     = 0;

    always #5 clk = ~clk;

    bus_decode_wdog #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_wen_i(m_wen_i), .m_sel_i(m_sel_i),
        .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_wen_o(s_wen_o), .s_sel_o(s_sel_o),
        .s0_stb_o(s0_stb_o), .s0_dat_i(s0_dat_i), .s0_ack_i(s0_ack_i),
        .s1_stb_o(s1_stb_o), .s1_dat_i(s1_dat_i), .s1_ack_i(s1_ack_i),
        .err_cnt_o(err_cnt_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Memory map as address ranges: 1 = device window, 0 = RAM, -1 = unmapped.
    function automatic int decodeTarget(input logic [31:0] adr);
        if (adr >= 32'h0001_0000 && adr <= 32'h0001_00FF) return 1;
        if (adr <= 32'h0000_FFFF) return 0;
        return -1;
    endfunction

    // One master transaction; delay = slave wait states (>= TIMEOUT means never acks).
    task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat, input logic wen,
                                 input logic [3:0] sel, input int delay, input bit abort);
        int          target = decodeTarget(adr);
        logic [31:0] rdata  = $urandom;
        int          stbCount = 0, otherSeen = 0, ackCyc = -1, errCyc = -1;
        int          limit = abort ? delay + 6 : 80;
        logic        selStb;
        logic [31:0] ackData = 32'd0;
        m_adr_i = adr; m_dat_i = dat; m_wen_i = wen; m_sel_i = sel;
        m_stb_i = 1'b1; m_cyc_i = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            s0_ack_i = 1'b0; s1_ack_i = 1'b0;
            s0_dat_i = $urandom; s1_dat_i = $urandom;
            if ((target != 0 && s0_stb_o) || (target != 1 && s1_stb_o)) otherSeen++;
            selStb = (target == 0) ? s0_stb_o : (target == 1) ? s1_stb_o : 1'b0;
            if (selStb) begin
                if (stbCount == 0) begin
                    checkOutput("s_adr", s_adr_o, adr);
                    checkOutput("s_dat", s_dat_o, dat);
                    checkOutput("s_wen", {31'd0, s_wen_o}, {31'd0, wen});
                    checkOutput("s_sel", {28'd0, s_sel_o}, {28'd0, sel});
                end
                if (stbCount == delay) begin
                    if (target == 0) begin s0_ack_i = 1'b1; s0_dat_i = rdata; end
                    else begin s1_ack_i = 1'b1; s1_dat_i = rdata; end
                end
                // Stray ack from the unselected slave must be ignored.
                if ($urandom_range(0, 1) == 1) begin
                    if (target == 0) s1_ack_i = 1'b1; else s0_ack_i = 1'b1;
                end
                stbCount++;
            end
            if (m_ack_o) begin ackCyc = c; ackData = m_dat_o; end
            if (m_err_o) errCyc = c;
            if (abort && c == 1) begin m_stb_i = 1'b0; m_cyc_i = 1'b0; end
            if (ackCyc >= 0 || errCyc >= 0) break;
        end
        s0_ack_i = 1'b0; s1_ack_i = 1'b0;
        checkOutput("rty", {31'd0, m_rty_o}, 32'd0);
        checkOutput("other_stb", otherSeen, 0);

        if (abort) begin
            checkOutput("abort_ack", ackCyc, -1);
            checkOutput("abort_err", errCyc, -1);
            checkOutput("abort_stb_cnt", stbCount, delay + 1);
        end else if (target < 0) begin
            checkOutput("unmap_err_cyc", errCyc, 1);
            checkOutput("unmap_stb_cnt", stbCount, 0);
        end else if (delay < TIMEOUT) begin
            checkOutput("ack_cyc", ackCyc, 2 + delay);
            checkOutput("ack_data", ackData, rdata);
            checkOutput("stb_cnt", stbCount, delay + 1);
        end else begin
            checkOutput("tmo_err_cyc", errCyc, TIMEOUT + 1);
            checkOutput("tmo_stb_cnt", stbCount, TIMEOUT);
        end

        if (ackCyc >= 0) begin
            m_stb_i = 1'b0; m_cyc_i = 1'b0;
            @(posedge clk); #1;
            checkOutput("ack_pulse", {31'd0, m_ack_o}, 32'd0);
            checkOutput("dat_hold", m_dat_o, rdata);
        end else if (errCyc >= 0) begin
            errCnt = (errCnt < 255) ? errCnt + 1 : 255;
            @(posedge clk); #1;
            checkOutput("err_held", {31'd0, m_err_o}, 32'd1);
            m_stb_i = 1'b0; m_cyc_i = 1'b0;
            @(posedge clk); #1;
            checkOutput("err_clear", {31'd0, m_err_o}, 32'd0);
        end else if (!abort) begin
            checkOutput("no_response", 0, 1);
            m_stb_i = 1'b0; m_cyc_i = 1'b0;
            @(posedge clk); #1;
        end
        checkOutput("err_cnt", {24'd0, err_cnt_o}, errCnt);
    endtask

    task automatic resetMidBusy();
        m_adr_i = 32'h0000_2000; m_dat_i = 32'h1234_5678; m_wen_i = 1'b1; m_sel_i = 4'hF;
        m_stb_i = 1'b1; m_cyc_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("rst_pre_stb", {31'd0, s0_stb_o}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        errCnt = 0;
        checkOutput("rst_stb0", {31'd0, s0_stb_o}, 32'd0);
        checkOutput("rst_stb1", {31'd0, s1_stb_o}, 32'd0);
        checkOutput("rst_ack", {31'd0, m_ack_o}, 32'd0);
        checkOutput("rst_err", {31'd0, m_err_o}, 32'd0);
        checkOutput("rst_adr", s_adr_o, 32'd0);
        checkOutput("rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
        reset = 1'b0; m_stb_i = 1'b0; m_cyc_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] edges [5];
        logic [31:0] adr;
        int          d;
        edges[0] = 32'h0000_FFFF; edges[1] = 32'h0001_0000; edges[2] = 32'h0001_00FF;
        edges[3] = 32'h0001_0100; edges[4] = 32'h0002_0000;

        reset = 1'b1;
        m_adr_i = 32'd0; m_dat_i = 32'd0; m_wen_i = 1'b0; m_sel_i = 4'd0;
        m_stb_i = 1'b0; m_cyc_i = 1'b0;
        s0_dat_i = 32'd0; s1_dat_i = 32'd0; s0_ack_i = 1'b0; s1_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_ack", {31'd0, m_ack_o}, 32'd0);
        checkOutput("reset_err", {31'd0, m_err_o}, 32'd0);
        checkOutput("reset_stb", {30'd0, s1_stb_o, s0_stb_o}, 32'd0);
        checkOutput("reset_mdat", m_dat_o, 32'd0);
        checkOutput("reset_sadr", s_adr_o, 32'd0);
        checkOutput("reset_sdat", s_dat_o, 32'd0);
        checkOutput("reset_wen_sel", {27'd0, s_wen_o, s_sel_o}, 32'd0);
        checkOutput("reset_err_cnt", {24'd0, err_cnt_o}, 32'd0);

        $display("[TB] directed cases");
        applyStimulus(32'h0000_1000, 32'h0, 1'b0, 4'hF, 0, 1'b0);
        applyStimulus(32'h0001_0004, 32'h55, 1'b1, 4'h1, 3, 1'b0);
        applyStimulus(32'h8000_0000, 32'h0, 1'b0, 4'hF, 0, 1'b0);
        applyStimulus(32'h0000_0040, 32'h0, 1'b0, 4'hF, 200, 1'b0);
        applyStimulus(32'h0000_0080, 32'h0, 1'b0, 4'hF, TIMEOUT - 1, 1'b0);
        applyStimulus(32'h0000_0100, 32'h0, 1'b0, 4'hF, 3, 1'b1);
        applyStimulus(32'h0001_0010, 32'hA5A5_0000, 1'b1, 4'hC, 1, 1'b0);
        resetMidBusy();

        $display("[TB] randomized transactions");
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       adr = $urandom_range(0, 32'h0000_FFFF);
                1:       adr = 32'h0001_0000 + $urandom_range(0, 255);
                2:       adr = $urandom;
                default: adr = edges[$urandom_range(0, 4)];
            endcase
            d = $urandom_range(0, 7);
            if (d == 5) d = TIMEOUT - 1;
            else if (d == 6) d = TIMEOUT;
            else if (d == 7) d = 200;
            applyStimulus(adr, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d, 1'b0);
        end

        $display("[TB] error counter saturation");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(32'h8000_0000 + 32'($urandom_range(0, 4095)), 32'd0, 1'b0, 4'hF, 0, 1'b0);
        end
        checkOutput("err_cnt_sat", {24'd0, err_cnt_o}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
